// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the FIFO write port.
// The arbiter uses the slave modport; the producer/FIFO side uses master.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_write_en;
  logic [DATA_W-1:0]         fifo_write_data;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_write_en, fifo_write_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_write_en, fifo_write_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking in front of the dual-clock FIFO write port.
// A grant ends on last, after MAX_BURST beats, or after IDLE_TIMEOUT idle cycles.
module fifo_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_write_arbiter_if.slave   bus
);

  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_BURST_C    = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_TIMEOUT_C = 8'(IDLE_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r;
  logic [GID_W-1:0]   grant_id_r;
  logic [GID_W-1:0]   rr_ptr_r;
  logic [7:0]         beat_cnt_r;
  logic [7:0]         idle_cnt_r;

  logic [GID_W-1:0]   winner_s;
  logic               any_req_s;
  int                 scan_idx_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [DATA_W-1:0]  write_data_s;
  logic               beat_s;
  logic               release_s;

  // Round-robin search starting just above the last winner.
  always_comb begin
    winner_s   = rr_ptr_r;
    any_req_s  = 1'b0;
    scan_idx_s = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!any_req_s && bus.req_valid[scan_idx_s]) begin
        any_req_s = 1'b1;
        winner_s  = GID_W'(scan_idx_s);
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Owner datapath: ready follows fifo_full directly so a full FIFO never takes a push.
  always_comb begin
    sel_valid_s  = bus.req_valid[grant_id_r];
    sel_last_s   = bus.req_last[grant_id_r];
    sel_data_s   = bus.req_data[int'(grant_id_r)*DATA_W +: DATA_W];
    ready_s      = '0;
    write_data_s = '0;
    if (state_r == GRANT) begin
      ready_s[grant_id_r] = !bus.fifo_full;
      write_data_s        = sel_data_s;
    end else begin
      ready_s      = '0;
      write_data_s = '0;
    end
    beat_s    = sel_valid_s & ready_s[grant_id_r];
    // Last and burst limit on the same beat collapse into one release.
    release_s = (beat_s && (sel_last_s || ((beat_cnt_r + 8'd1) == MAX_BURST_C))) ||
                (!sel_valid_s && ((idle_cnt_r + 8'd1) == IDLE_TIMEOUT_C));
  end

  // Arbitration FSM with burst and idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= GID_W'(NUM_REQ - 1);
      beat_cnt_r <= 8'd0;
      idle_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_id_r <= winner_s;
            rr_ptr_r   <= winner_s;
            beat_cnt_r <= 8'd0;
            idle_cnt_r <= 8'd0;
            state_r    <= GRANT;
          end
        end
        GRANT: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
          end
          // A full-stall with valid high is not idleness.
          if (sel_valid_s) begin
            idle_cnt_r <= 8'd0;
          end else begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
          end
          if (release_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready       = ready_s;
  assign bus.fifo_write_en   = beat_s;
  assign bus.fifo_write_data = write_data_s;
  assign bus.grant_id        = grant_id_r;
  assign bus.busy            = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: inputs change on the falling edge and
// outputs are compared 1 time unit later against hand-computed values.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(4), .IDLE_TIMEOUT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want normal end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [7:0] val);
    bus.req_data[idx*DATA_W +: DATA_W] = val;
  endtask

  // Compare all outputs for the current cycle, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic exp_busy, input logic [1:0] exp_gid,
                     input logic [3:0] exp_ready, input logic exp_we, input logic [7:0] exp_wdata);
    #1;
    check_eq({tag, ".busy"},  32'(bus.busy),            32'(exp_busy));
    check_eq({tag, ".gid"},   32'(bus.grant_id),        32'(exp_gid));
    check_eq({tag, ".ready"}, 32'(bus.req_ready),       32'(exp_ready));
    check_eq({tag, ".we"},    32'(bus.fifo_write_en),   32'(exp_we));
    check_eq({tag, ".wdata"}, 32'(bus.fifo_write_data), 32'(exp_wdata));
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    cyc("rst", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [1:0] order [3];
    int group [3];
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;

    // Single requester 2, three beats ending in last.
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 8'hA1);
    cyc("t1.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t1.b1",  1'b1, 2'd2, 4'b0100, 1'b1, 8'hA1);
    set_data(2, 8'hA2);
    cyc("t1.b2",  1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2);
    set_data(2, 8'hA3);
    bus.req_last = 4'b0100;
    cyc("t1.b3",  1'b1, 2'd2, 4'b0100, 1'b1, 8'hA3);
    bus.req_valid = '0;
    bus.req_last  = '0;
    cyc("t1.rel", 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00);

    // Requesters 0,1,3 contending with single-beat bursts.
    do_reset();
    bus.req_valid = 4'b1011;
    bus.req_last  = 4'b1011;
    set_data(0, 8'h10);
    set_data(1, 8'h11);
    set_data(3, 8'h13);
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3;
    cyc("t2.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    for (int r = 0; r < 6; r++) begin
      cyc("t2.gnt", 1'b1, order[r%3], 4'(1 << order[r%3]), 1'b1, 8'h10 + 8'(order[r%3]));
      if (r == 5) begin
        bus.req_valid = '0;
        bus.req_last  = '0;
      end
      cyc("t2.gap", 1'b0, order[r%3], 4'b0000, 1'b0, 8'h00);
    end

    // Requester 1 streams 10 beats without last: grants of 4,4,2 then idle timeout.
    do_reset();
    group[0] = 4; group[1] = 4; group[2] = 2;
    k = 0;
    bus.req_valid = 4'b0010;
    for (int g = 0; g < 3; g++) begin
      set_data(1, 8'h20 + 8'(k));
      cyc("t3.idle", 1'b0, (g == 0) ? 2'd0 : 2'd1, 4'b0000, 1'b0, 8'h00);
      for (int b = 0; b < group[g]; b++) begin
        set_data(1, 8'h20 + 8'(k));
        cyc("t3.beat", 1'b1, 2'd1, 4'b0010, 1'b1, 8'h20 + 8'(k));
        k++;
      end
    end
    bus.req_valid = '0;
    set_data(1, 8'h00);
    repeat (3) cyc("t3.wait", 1'b1, 2'd1, 4'b0010, 1'b0, 8'h00);
    cyc("t3.tmo", 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00);
    check_eq("t3.count", 32'(k), 32'd10);

    // Requester 0 stalled by fifo_full for 5 cycles; last coincides with MAX_BURST.
    do_reset();
    bus.req_valid = 4'b0001;
    set_data(0, 8'h30);
    cyc("t4.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t4.b0",  1'b1, 2'd0, 4'b0001, 1'b1, 8'h30);
    set_data(0, 8'h31);
    bus.fifo_full = 1'b1;
    repeat (5) cyc("t4.full", 1'b1, 2'd0, 4'b0000, 1'b0, 8'h31);
    bus.fifo_full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      set_data(0, 8'h30 + 8'(b));
      bus.req_last = (b == 3) ? 4'b0001 : 4'b0000;
      cyc("t4.beat", 1'b1, 2'd0, 4'b0001, 1'b1, 8'h30 + 8'(b));
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    cyc("t4.rel",  1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t4.rel2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);

    // Requester 2 goes quiet for IDLE_TIMEOUT cycles; pending requester 3 follows.
    do_reset();
    bus.req_valid = 4'b1100;
    bus.req_last  = 4'b1000;
    set_data(2, 8'h40);
    set_data(3, 8'h53);
    cyc("t5.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t5.b0",  1'b1, 2'd2, 4'b0100, 1'b1, 8'h40);
    bus.req_valid = 4'b1000;
    set_data(2, 8'h00);
    repeat (3) cyc("t5.quiet", 1'b1, 2'd2, 4'b0100, 1'b0, 8'h00);
    cyc("t5.rel", 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00);
    cyc("t5.g3",  1'b1, 2'd3, 4'b1000, 1'b1, 8'h53);
    bus.req_valid = '0;
    bus.req_last  = '0;
    cyc("t5.end", 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00);

    // Asynchronous reset during beat 2 of a burst from requester 0.
    do_reset();
    bus.req_valid = 4'b0011;
    set_data(0, 8'h60);
    set_data(1, 8'h77);
    cyc("t6.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t6.b1",  1'b1, 2'd0, 4'b0001, 1'b1, 8'h60);
    set_data(0, 8'h61);
    #1;
    check_eq("t6.b2.we",    32'(bus.fifo_write_en),   32'd1);
    check_eq("t6.b2.wdata", 32'(bus.fifo_write_data), 32'h61);
    rst_n = 1'b0;
    #1;
    check_eq("t6.rst.busy",  32'(bus.busy),            32'd0);
    check_eq("t6.rst.ready", 32'(bus.req_ready),       32'd0);
    check_eq("t6.rst.we",    32'(bus.fifo_write_en),   32'd0);
    check_eq("t6.rst.wdata", 32'(bus.fifo_write_data), 32'd0);
    check_eq("t6.rst.gid",   32'(bus.grant_id),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_data(0, 8'h62);
    cyc("t6.arb2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
    cyc("t6.g0",   1'b1, 2'd0, 4'b0001, 1'b1, 8'h62);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the dual-clock FIFO among NUM_REQ producers in the write clock domain.
- Uses round-robin arbitration with burst locking: a winner keeps the port until it signals last, hits MAX_BURST beats, or idles for IDLE_TIMEOUT cycles.
- Honours the FIFO full flag, so no requester can push into a full FIFO.
- Sits directly in front of the FIFO write_en / write_data / full interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width; matches the FIFO write_data width.
- MAX_BURST, 4, maximum beats per grant before forced release (1..255).
- IDLE_TIMEOUT, 3, consecutive cycles with granted req_valid low before forced release (1..255).

Ports:
- clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  per-requester final beat of burst.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- fifo_full  input  1  FIFO full flag.
- fifo_write_en  output  1  FIFO write enable.
- fifo_write_data  output  DATA_W  FIFO write data.
- grant_id  output  clog2(NUM_REQ)  index of the current or last owner.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset:
  - one clock and one reset only; reset is asynchronous, active-low.
  - state=IDLE, grant_id=0, busy=0, beat_cnt=0, idle_cnt=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0, fifo_write_en=0, fifo_write_data=0.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Register grant_id to the winner, set rr_ptr to the winner, clear both counters, and go to GRANT next cycle.
  - This gives a 1-cycle arbitration latency.
  - With no request, stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full. It is combinational from fifo_full and state; all other ready bits are 0.
  - beat = req_valid[grant_id] & req_ready[grant_id].
  - fifo_write_en = beat, combinational.
  - fifo_write_data = req_data of grant_id while in GRANT, otherwise 0.
- Release conditions; any one causes a return to IDLE next cycle:
  - (a) beat with req_last[grant_id]=1.
  - (b) beat that makes beat_cnt reach MAX_BURST.
  - (c) idle_cnt reaching IDLE_TIMEOUT.
- Counters:
  - beat_cnt increments on each beat.
  - idle_cnt increments each GRANT cycle with req_valid[grant_id]=0, and clears when req_valid[grant_id]=1.
  - Cycles stalled by fifo_full with valid high do NOT count toward the timeout.
- Release always passes through IDLE: one bubble cycle minimum between grants.
- Simultaneous last and MAX_BURST on the same beat: single release, no double action.
- fifo_full while valid: no write, no beat_cnt change, grant held indefinitely.
- Other requesters' valid/last are ignored while not granted; data is never dropped or duplicated.
- busy = (state==GRANT). grant_id holds its value in IDLE until the next grant.
- Reset mid-burst: immediate return to reset values and the ready path closes asynchronously. A requester must re-present its beat after reset.
- Widths: both counters are 8 bits with no wrap in legal use, because release occurs at the limit.

Test Plan:
- Single requester 2, 3 beats (0xA1,0xA2,0xA3), last on 3rd, fifo_full=0 -> grant_id=2 one cycle after valid; fifo_write_en high 3 consecutive cycles with those data; busy drops next cycle; ready only on bit 2.
- Requesters 0,1,3 all valid continuously, each 1-beat bursts with last=1 -> grant order 0,1,3,0,1,3; each grant separated by one IDLE cycle.
- Requester 1 streams 10 beats, never asserts last, MAX_BURST=4 -> release after 4 beats; if requester 1 is the only requester, it is re-granted; 10 beats are written in grants of 4,4,2, in order, with no loss.
- Requester 0 granted, fifo_full asserted for 5 cycles mid-burst -> req_ready[0]=0 and fifo_write_en=0 during full; no timeout; burst resumes from the same beat after full deasserts.
- Requester 2 granted then drops valid for 3 cycles with IDLE_TIMEOUT=3 -> release to IDLE; pending requester 3 is granted next.
- Assert rst_n=0 during beat 2 of a 4-beat burst -> all outputs return to reset values at once; after release, requester 0 wins first arbitration.
